// File: rtl/kronos_types.sv
// Shared types for the kronos memory subsystem: arbiter FSM states and bus constants.
package kronos_types;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] MEM_FULL_MASK = 4'hF;

endpackage

// File: rtl/kronos_mem_arb.sv
// Shares one memory port between instruction fetch and load/store. Data normally wins,
// a streak counter bounds fetch starvation, and an optional watchdog aborts stuck grants.
module kronos_mem_arb
  import kronos_types::*;
#(
  parameter int unsigned DATA_STREAK = 4,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_wr_en,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output arb_state_t  arb_state
);

  // Handshake: a requester holds req and payload until its ack or err; ack/err are
  // combinational from mem_ack in the same cycle, and mem_req stays high for the whole grant.

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK);
  localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);
  localparam bit         WDOG_EN    = (TIMEOUT != 0);

  arb_state_t  state, state_n;
  logic [3:0]  streak, streak_n;
  logic [7:0]  wdog, wdog_n;
  logic        own_i, own_d, timeout, done;
  logic        elig_i, elig_d, pick_i, pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      streak <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
      wdog   <= wdog_n;
    end
  end

  always_comb begin
    own_i    = (state == ARB_GNT_I);
    own_d    = (state == ARB_GNT_D);
    timeout  = WDOG_EN && (own_i || own_d) && !mem_ack && (wdog == WDOG_LAST);
    done     = (own_i || own_d) && (mem_ack || timeout);
    // An aborted owner sits out the re-arbitration so the port is released or handed over.
    elig_i   = instr_req && !(timeout && own_i);
    elig_d   = data_req && !(timeout && own_d);
    pick_i   = elig_i && (!elig_d || (streak == STREAK_MAX));
    pick_d   = elig_d && !pick_i;
    state_n  = state;
    streak_n = streak;
    wdog_n   = wdog;
    if ((state == ARB_IDLE) || done) begin
      wdog_n = '0;
      if (pick_i) begin
        state_n  = ARB_GNT_I;
        streak_n = '0;
      end else if (pick_d) begin
        state_n = ARB_GNT_D;
        if (!instr_req) begin
          streak_n = '0;
        end else if (streak != STREAK_MAX) begin
          streak_n = streak + 4'd1;
        end
      end else begin
        state_n = ARB_IDLE;
      end
    end else begin
      wdog_n = wdog + 8'd1;
    end
  end

  always_comb begin
    mem_req     = own_i || own_d;
    mem_addr    = own_d ? data_addr : (own_i ? instr_addr : 32'h0);
    mem_wr_en   = own_d && data_wr_en;
    mem_mask    = own_d ? data_mask : (own_i ? MEM_FULL_MASK : 4'h0);
    mem_wdata   = own_d ? data_wdata : 32'h0;
    // Completions are dropped when the requester let go early or reset is in progress.
    instr_ack   = own_i && mem_ack && instr_req && !rst;
    instr_err   = own_i && timeout && instr_req && !rst;
    data_ack    = own_d && mem_ack && data_req && !rst;
    data_err    = own_d && timeout && data_req && !rst;
    instr_rdata = mem_rdata;
    data_rdata  = mem_rdata;
    arb_state   = state;
  end

endmodule
